// File: rtl/dfi_lp_pkg.sv
// Shared types and default parameters for the DFI low-power handshake controller.
package dfi_lp_pkg;

    // Per-channel handshake states
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LP,
        EXIT,
        BACKOFF
    } lp_state_e;

    // Cycles req may stay high without ack before it must drop (>= 2)
    localparam int DEF_TLP_RESP       = 8;
    // Cycles ack may linger after req drops before an exit error is flagged
    localparam int DEF_TLP_WAKEUP_MAX = 64;
    // Width of the DFI wakeup codes
    localparam int DEF_WAKEUP_W       = 6;

endpackage

// File: rtl/dfi_lp_chan_fsm.sv
// One DFI low-power channel: request/acknowledge FSM, response and wakeup
// counters, and registered DFI-facing outputs.
module dfi_lp_chan_fsm
    import dfi_lp_pkg::*;
#(
    parameter int TLP_RESP       = DEF_TLP_RESP,
    parameter int TLP_WAKEUP_MAX = DEF_TLP_WAKEUP_MAX,
    parameter int WAKEUP_W       = DEF_WAKEUP_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                init_start,
    input  logic                busy,
    input  logic                lp_enter,
    input  logic [WAKEUP_W-1:0] wakeup_in,
    input  logic                lp_ack,
    output logic                lp_req,
    output logic [WAKEUP_W-1:0] lp_wakeup,
    output logic                in_lp,
    output logic                timeout,
    output logic                exit_err,
    output logic                proto_err
);

    localparam int RESP_CW = $clog2(TLP_RESP + 1);
    localparam int WAKE_CW = $clog2(TLP_WAKEUP_MAX + 1);
    localparam logic [RESP_CW-1:0] RESP_LAST = RESP_CW'(TLP_RESP - 1);
    localparam logic [RESP_CW-1:0] RESP_MAX  = RESP_CW'(TLP_RESP);
    localparam logic [WAKE_CW-1:0] WAKE_LAST = WAKE_CW'(TLP_WAKEUP_MAX - 1);
    localparam logic [WAKE_CW-1:0] WAKE_MAX  = WAKE_CW'(TLP_WAKEUP_MAX);

    lp_state_e           state_reg, state_next;
    logic [RESP_CW-1:0]  resp_cnt_reg, resp_cnt_next;
    logic [WAKE_CW-1:0]  wake_cnt_reg, wake_cnt_next;
    logic [WAKEUP_W-1:0] wakeup_reg, wakeup_next;
    logic                req_reg, in_lp_reg, ack_d_reg;
    logic                timeout_reg, timeout_next;
    logic                exit_err_reg, exit_err_next;
    logic                proto_err_reg, proto_err_next;
    logic                ack_rise;

    // An ack edge while no request is outstanding is a PHY protocol violation
    assign ack_rise = lp_ack & ~ack_d_reg;

    // State, counters and outputs; outputs follow the next state so they line up with transitions
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            resp_cnt_reg  <= '0;
            wake_cnt_reg  <= '0;
            wakeup_reg    <= '0;
            req_reg       <= 1'b0;
            in_lp_reg     <= 1'b0;
            ack_d_reg     <= 1'b0;
            timeout_reg   <= 1'b0;
            exit_err_reg  <= 1'b0;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            resp_cnt_reg  <= resp_cnt_next;
            wake_cnt_reg  <= wake_cnt_next;
            wakeup_reg    <= wakeup_next;
            req_reg       <= (state_next == REQ) || (state_next == LP);
            in_lp_reg     <= (state_next == LP);
            ack_d_reg     <= lp_ack;
            timeout_reg   <= timeout_next;
            exit_err_reg  <= exit_err_next;
            proto_err_reg <= proto_err_next;
        end
    end

    // Next-state, counter and pulse decisions; counters fall back to zero on any state change
    always_comb begin
        state_next     = state_reg;
        resp_cnt_next  = '0;
        wake_cnt_next  = '0;
        wakeup_next    = wakeup_reg;
        timeout_next   = 1'b0;
        exit_err_next  = 1'b0;
        proto_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                proto_err_next = ack_rise;
                // Wakeup code is captured only here, so later input changes wait for the next entry
                if (lp_enter && !busy && !init_start && !lp_ack) begin
                    state_next  = REQ;
                    wakeup_next = wakeup_in;
                end
            end
            REQ: begin
                // Withdrawal beats both ack and timeout
                if (init_start || !lp_enter) begin
                    state_next = EXIT;
                end else if (lp_ack) begin
                    state_next = LP;
                end else if (resp_cnt_reg == RESP_LAST) begin
                    state_next   = BACKOFF;
                    timeout_next = 1'b1;
                end else begin
                    resp_cnt_next = (resp_cnt_reg < RESP_MAX) ? resp_cnt_reg + 1'b1 : resp_cnt_reg;
                end
            end
            LP: begin
                if (!lp_ack) begin
                    state_next     = EXIT;
                    proto_err_next = 1'b1;
                end else if (init_start || !lp_enter) begin
                    state_next = EXIT;
                end
            end
            EXIT: begin
                if (!lp_ack) begin
                    state_next = IDLE;
                end else begin
                    wake_cnt_next = (wake_cnt_reg < WAKE_MAX) ? wake_cnt_reg + 1'b1 : wake_cnt_reg;
                    // Saturation past WAKE_LAST keeps this a single pulse
                    exit_err_next = (wake_cnt_reg == WAKE_LAST);
                end
            end
            BACKOFF: begin
                proto_err_next = ack_rise;
                // No automatic retry: power management must withdraw before asking again
                if (!lp_enter) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign lp_req    = req_reg;
    assign lp_wakeup = wakeup_reg;
    assign in_lp     = in_lp_reg;
    assign timeout   = timeout_reg;
    assign exit_err  = exit_err_reg;
    assign proto_err = proto_err_reg;

endmodule

// File: rtl/dfi_lp_handshake.sv
// MC-side DFI low-power handshake: independent ctrl and data channels sharing init_start.
module dfi_lp_handshake
    import dfi_lp_pkg::*;
#(
    parameter int TLP_RESP       = DEF_TLP_RESP,
    parameter int TLP_WAKEUP_MAX = DEF_TLP_WAKEUP_MAX,
    parameter int WAKEUP_W       = DEF_WAKEUP_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                init_start,
    input  logic                cmd_busy,
    input  logic                rw_busy,
    input  logic                ctrl_lp_enter,
    input  logic                data_lp_enter,
    input  logic [WAKEUP_W-1:0] ctrl_wakeup_in,
    input  logic [WAKEUP_W-1:0] data_wakeup_in,
    input  logic                lp_ctrl_ack,
    input  logic                lp_data_ack,
    output logic                lp_ctrl_req,
    output logic                lp_data_req,
    output logic [WAKEUP_W-1:0] lp_ctrl_wakeup,
    output logic [WAKEUP_W-1:0] lp_data_wakeup,
    output logic                ctrl_in_lp,
    output logic                data_in_lp,
    output logic                ctrl_timeout,
    output logic                data_timeout,
    output logic                ctrl_exit_err,
    output logic                data_exit_err,
    output logic                ctrl_proto_err,
    output logic                data_proto_err
);

    // Channel 0 is ctrl (gated by command traffic), channel 1 is data (gated by read/write traffic)
    localparam int NCH = 2;

    logic [NCH-1:0]      busy_vec, enter_vec, ack_vec;
    logic [NCH-1:0]      req_vec, in_lp_vec, timeout_vec, exit_err_vec, proto_err_vec;
    logic [WAKEUP_W-1:0] wakeup_in_arr  [NCH];
    logic [WAKEUP_W-1:0] wakeup_out_arr [NCH];

    assign busy_vec         = {rw_busy, cmd_busy};
    assign enter_vec        = {data_lp_enter, ctrl_lp_enter};
    assign ack_vec          = {lp_data_ack, lp_ctrl_ack};
    assign wakeup_in_arr[0] = ctrl_wakeup_in;
    assign wakeup_in_arr[1] = data_wakeup_in;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            dfi_lp_chan_fsm #(
                .TLP_RESP       (TLP_RESP),
                .TLP_WAKEUP_MAX (TLP_WAKEUP_MAX),
                .WAKEUP_W       (WAKEUP_W)
            ) u_chan (
                .clock      (clock),
                .reset      (reset),
                .init_start (init_start),
                .busy       (busy_vec[gi]),
                .lp_enter   (enter_vec[gi]),
                .wakeup_in  (wakeup_in_arr[gi]),
                .lp_ack     (ack_vec[gi]),
                .lp_req     (req_vec[gi]),
                .lp_wakeup  (wakeup_out_arr[gi]),
                .in_lp      (in_lp_vec[gi]),
                .timeout    (timeout_vec[gi]),
                .exit_err   (exit_err_vec[gi]),
                .proto_err  (proto_err_vec[gi])
            );
        end
    endgenerate

    assign lp_ctrl_req    = req_vec[0];
    assign lp_data_req    = req_vec[1];
    assign lp_ctrl_wakeup = wakeup_out_arr[0];
    assign lp_data_wakeup = wakeup_out_arr[1];
    assign ctrl_in_lp     = in_lp_vec[0];
    assign data_in_lp     = in_lp_vec[1];
    assign ctrl_timeout   = timeout_vec[0];
    assign data_timeout   = timeout_vec[1];
    assign ctrl_exit_err  = exit_err_vec[0];
    assign data_exit_err  = exit_err_vec[1];
    assign ctrl_proto_err = proto_err_vec[0];
    assign data_proto_err = proto_err_vec[1];

endmodule
